// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial arithmetic unit.
//   state_e   : sequencer state encoding (IDLE / RUN / DONE, 2 bits)
//   cnt_width : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must index bits 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/serial_add_ctrl_add1.sv
// ---------------------------------------------------------------------------
// add1
// One-bit full adder cell, the only arithmetic element of the serial unit.
//   a_i, b_i : addend bits
//   ci_i     : carry in
//   s_o      : sum bit
//   co_o     : carry out
// ---------------------------------------------------------------------------
module add1 (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract sequencer. Operands are latched on an accepted
// start, streamed LSB-first through a single add1 cell with a registered
// carry, and the result is returned with carry/overflow/zero flags and a
// one-cycle done pulse. One operation takes WIDTH+2 cycles.
//   clk        : clock, all state on rising edge
//   rst_n      : synchronous active-low reset
//   start      : request, accepted only while ready=1
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   ready      : high in IDLE only
//   done       : one-cycle pulse, result and flags valid
//   result     : sum/difference, held until the next accepted start
//   carry_out  : carry from the MSB (subtract: 1 = no borrow)
//   overflow   : signed two's-complement overflow
//   zero       : result == 0
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           st_q,  st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q,  cy_d;
  logic             co_q,  co_d;
  logic             ov_q,  ov_d;
  logic             z_q,   z_d;

  logic             sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] res_shift_s;

  add1 u_add1 (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .ci_i (cy_q),
    .s_o  (sum_s),
    .co_o (cout_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits in result[0].
  assign res_shift_s = {sum_s, res_q[WIDTH-1:1]};

  // Next-state, datapath shift and flag capture.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    cy_d  = cy_q;
    co_d  = co_q;
    ov_d  = ov_q;
    z_d   = z_q;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
          opa_d = a;
          opb_d = sub ? ~b : b;
          cy_d  = sub;
          cnt_d = {CW{1'b0}};
          res_d = {WIDTH{1'b0}};
          co_d  = 1'b0;
          ov_d  = 1'b0;
          z_d   = 1'b0;
          st_d  = ST_RUN;
        end else begin
          st_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        res_d = res_shift_s;
        cy_d  = cout_s;
        if (cnt_q == CNT_LAST) begin
          // cy_q is the carry into the MSB at this bit.
          ov_d = cy_q ^ cout_s;
          co_d = cout_s;
          z_d  = (res_shift_s == {WIDTH{1'b0}});
          st_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= {CW{1'b0}};
      opa_q <= {WIDTH{1'b0}};
      opb_q <= {WIDTH{1'b0}};
      res_q <= {WIDTH{1'b0}};
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      cy_q  <= cy_d;
      co_q  <= co_d;
      ov_q  <= ov_d;
      z_q   <= z_d;
    end
  end

  assign ready     = (st_q == ST_IDLE);
  assign done      = (st_q == ST_DONE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
  assign zero      = z_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl (WIDTH=4) with hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int n_assert;
  int n_fail;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: accept, count cycles to done, check result and flags.
  task automatic do_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                       input logic isub, input logic [3:0] eres, input logic eco,
                       input logic eov, input logic ez);
    int cyc;
    check_eq({tag, "_ready_idle"}, 32'(ready), 32'd1);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub;
    check_eq({tag, "_ready_run"}, 32'(ready), 32'd0);
    check_eq({tag, "_res_clr"}, 32'(result), 32'd0);
    check_eq({tag, "_flags_clr"}, {29'd0, carry_out, overflow, zero}, 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check_eq({tag, "_result"}, 32'(result), 32'(eres));
    check_eq({tag, "_cout"}, 32'(carry_out), 32'(eco));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(eov));
    check_eq({tag, "_zero"}, 32'(zero), 32'(ez));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(ready), 32'd1);
    check_eq({tag, "_res_hold"}, 32'(result), 32'(eres));
  endtask

  initial begin
    int ndone;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add3_5",  4'd3,  4'd5, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
    do_op("sub7_2",  4'd7,  4'd2, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
    do_op("add15_1", 4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    do_op("sub8_1",  4'd8,  4'd1, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0);
    do_op("sub0_1",  4'd0,  4'd1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);

    // start held high: only operands sampled in IDLE count.
    a = 4'd3; b = 4'd5; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      ndone += int'(done);
      check_eq($sformatf("hold_ready_%0d", n), 32'(ready), 32'((n == 5) || (n == 11)));
      if (n == 4) begin
        check_eq("hold_res_a", 32'(result), 32'd8);
      end else if (n == 10) begin
        check_eq("hold_res_b", 32'(result), 32'd5);
        check_eq("hold_cout_b", 32'(carry_out), 32'd1);
      end else begin
        check_eq($sformatf("hold_done_%0d", n), 32'(done), 32'd0);
      end
      if (n == 5) begin
        a = 4'd7; b = 4'd2; sub = 1'b1;
      end else begin
        a = 4'(n + 9); b = 4'(14 - n); sub = ~sub;
      end
      if (n == 11) start = 1'b0;
    end
    check_eq("hold_ndone", 32'(ndone), 32'd2);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 4'd5; b = 4'd6; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      ndone += int'(done);
      @(negedge clk);
    end
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    do_op("post_abort", 4'd3, 4'd5, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
